// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: writeback controller and the only driver of the register-file write port.
// It merges single-cycle ALU results with buffered LSU load responses into at most one
// write per cycle. The ALU has priority. A starvation counter forces a load drain after
// STARVE_MAX ALU-won cycles while loads are waiting.
// A busy scoreboard marks registers that have loads pending in the FIFO or in the output stage.
// Optional feature macro: WB_BYPASS_EN adds same-cycle write-to-read forwarding ports.
module rf_wb_ctrl #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic [4:0]  rd,
    output logic        write_e,
    output logic [31:0] write_d,
    output logic [31:0] busy,
    output logic        wb_err
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  byp_rs,
    input  logic [4:0]  byp_rt,
    output logic        byp_hit1,
    output logic [31:0] byp_data1,
    output logic        byp_hit2,
    output logic [31:0] byp_data2
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SCNT_W = $clog2(STARVE_MAX + 1);

    // FIFO control state
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    // FIFO storage (data only, not reset)
    logic [4:0]        mem_rd_q   [DEPTH];
    logic [4:0]        mem_rd_d   [DEPTH];
    logic [31:0]       mem_data_q [DEPTH];
    logic [31:0]       mem_data_d [DEPTH];
    // Arbitration / output stage state
    logic [SCNT_W-1:0] starve_q, starve_d;
    logic              alu_stall_q, alu_stall_d;
    logic              wb_err_q, wb_err_d;
    logic [4:0]        rd_q, rd_d;
    logic              write_e_q, write_e_d;
    logic [31:0]       write_d_q, write_d_d;
    logic              out_load_q, out_load_d;

    logic fifo_empty, fifo_full;
    logic alu_win, pop, push;
    logic [31:0] busy_v;

    // Arbitration decode: ALU first, FIFO head second. x0 destinations never write.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        alu_win    = alu_valid && (alu_rd != 5'd0) && !alu_stall_q;
        pop        = !alu_win && !fifo_empty;
        // A load to x0 is accepted by the handshake but never stored.
        push       = lsu_valid && !fifo_full && (lsu_rd != 5'd0);
    end

    // Next-state logic for FIFO, starvation counter, output stage and error flag
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_rd_d    = mem_rd_q;
        mem_data_d  = mem_data_q;
        starve_d    = starve_q;
        alu_stall_d = 1'b0;
        wb_err_d    = wb_err_q;
        rd_d        = rd_q;
        write_e_d   = 1'b0;
        write_d_d   = write_d_q;
        out_load_d  = 1'b0;

        if (push) begin
            mem_rd_d[wr_ptr_q]   = lsu_rd;
            mem_data_d[wr_ptr_q] = lsu_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (alu_win) begin
            write_e_d = 1'b1;
            rd_d      = alu_rd;
            write_d_d = alu_data;
        end else if (pop) begin
            write_e_d  = 1'b1;
            rd_d       = mem_rd_q[rd_ptr_q];
            write_d_d  = mem_data_q[rd_ptr_q];
            out_load_d = 1'b1;
        end

        // Count ALU wins only while loads are waiting. A drain or an empty FIFO resets the count.
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (alu_win && (starve_q != SCNT_W'(STARVE_MAX))) begin
            starve_d = starve_q + 1'b1;
        end
        // Hitting the limit stalls the ALU for exactly one cycle, and that cycle's pop clears it.
        alu_stall_d = (starve_d == SCNT_W'(STARVE_MAX));

        // An ALU result presented during a stall is dropped and flagged until reset.
        if (alu_valid && alu_stall_q) begin
            wb_err_d = 1'b1;
        end
    end

    // Control and output registers, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            starve_q    <= '0;
            alu_stall_q <= 1'b0;
            wb_err_q    <= 1'b0;
            rd_q        <= 5'd0;
            write_e_q   <= 1'b0;
            write_d_q   <= 32'd0;
            out_load_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            starve_q    <= starve_d;
            alu_stall_q <= alu_stall_d;
            wb_err_q    <= wb_err_d;
            rd_q        <= rd_d;
            write_e_q   <= write_e_d;
            write_d_q   <= write_d_d;
            out_load_q  <= out_load_d;
        end
    end

    // FIFO storage; occupancy is tracked by the pointers, so no reset is needed here
    always_ff @(posedge clk) begin
        mem_rd_q   <= mem_rd_d;
        mem_data_q <= mem_data_d;
    end

    // Busy scoreboard: occupied FIFO slots plus a load held in the output stage
    always_comb begin
        logic [PTR_W-1:0] off;
        busy_v = 32'd0;
        off    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr_q;
            if (CNT_W'(off) < count_q) begin
                busy_v = busy_v | (32'd1 << mem_rd_q[i]);
            end
        end
        if (write_e_q && out_load_q) begin
            busy_v = busy_v | (32'd1 << rd_q);
        end
        busy_v[0] = 1'b0;
    end

    assign busy      = busy_v;
    assign lsu_ready = !fifo_full;
    assign alu_stall = alu_stall_q;
    assign wb_err    = wb_err_q;
    assign rd        = rd_q;
    assign write_e   = write_e_q;
    assign write_d   = write_d_q;

`ifdef WB_BYPASS_EN
    // Same-cycle forwarding of the write being committed this cycle
    always_comb begin
        byp_hit1  = write_e_q && (rd_q == byp_rs) && (rd_q != 5'd0);
        byp_hit2  = write_e_q && (rd_q == byp_rt) && (rd_q != 5'd0);
        byp_data1 = write_d_q;
        byp_data2 = write_d_q;
    end
`endif

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed testbench for rf_wb_ctrl (default build, DEPTH=4, STARVE_MAX=3).
module tb_rf_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [4:0]  rd;
    logic        write_e;
    logic [31:0] write_d;
    logic [31:0] busy;
    logic        wb_err;

    int n_checks = 0;
    int n_fail   = 0;

    rf_wb_ctrl #(.DEPTH(4), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rd(rd), .write_e(write_e), .write_d(write_d), .busy(busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs driven now are captured at the edge, outputs sampled 1ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        alu_valid = v; alu_rd = r; alu_data = d;
    endtask

    task automatic drive_lsu(input logic v, input logic [4:0] r, input logic [31:0] d);
        lsu_valid = v; lsu_rd = r; lsu_data = d;
    endtask

    initial begin
        rst = 1'b1;
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b0, 5'd0, 32'd0);
        #12;
        // Reset state
        chk("rst_write_e", {31'd0, write_e}, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_write_d", write_d, 32'd0);
        chk("rst_alu_stall", {31'd0, alu_stall}, 32'd0);
        chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
        chk("rst_lsu_ready", {31'd0, lsu_ready}, 32'd1);
        chk("rst_busy", busy, 32'd0);
        #10 rst = 1'b0;
        tick();

        // ALU write: one-cycle latency, one cycle only
        drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
        tick();
        chk("alu_we", {31'd0, write_e}, 32'd1);
        chk("alu_rd", {27'd0, rd}, 32'd5);
        chk("alu_wd", write_d, 32'hDEADBEEF);
        drive_alu(1'b0, 5'd0, 32'd0);
        tick();
        chk("alu_we_drop", {31'd0, write_e}, 32'd0);

        // Load with ALU idle
        chk("ld_ready", {31'd0, lsu_ready}, 32'd1);
        drive_lsu(1'b1, 5'd7, 32'h1234);
        tick();
        drive_lsu(1'b0, 5'd0, 32'd0);
        chk("ld_busy_n1", busy, 32'h0000_0080);
        chk("ld_we_n1", {31'd0, write_e}, 32'd0);
        tick();
        chk("ld_we_n2", {31'd0, write_e}, 32'd1);
        chk("ld_rd_n2", {27'd0, rd}, 32'd7);
        chk("ld_wd_n2", write_d, 32'h1234);
        chk("ld_busy_n2", busy, 32'h0000_0080);
        tick();
        chk("ld_busy_n3", busy, 32'd0);
        chk("ld_we_n3", {31'd0, write_e}, 32'd0);

        // Conflict and starvation: one load queued while the ALU writes every cycle
        drive_alu(1'b1, 5'd1, 32'h101);
        drive_lsu(1'b1, 5'd9, 32'h99);
        tick();
        drive_lsu(1'b0, 5'd0, 32'd0);
        chk("st_rd1", {27'd0, rd}, 32'd1);
        chk("st_busy", busy, 32'h0000_0200);
        for (int i = 2; i <= 4; i++) begin
            drive_alu(1'b1, 5'(i), 32'h100 + 32'(i));
            tick();
            chk("st_alu_rd", {27'd0, rd}, 32'(i));
            chk("st_alu_we", {31'd0, write_e}, 32'd1);
            chk("st_stall", {31'd0, alu_stall}, (i == 4) ? 32'd1 : 32'd0);
        end
        drive_alu(1'b0, 5'd0, 32'd0);
        tick();
        chk("st_ld_we", {31'd0, write_e}, 32'd1);
        chk("st_ld_rd", {27'd0, rd}, 32'd9);
        chk("st_ld_wd", write_d, 32'h99);
        chk("st_stall_clr", {31'd0, alu_stall}, 32'd0);
        chk("st_wb_err", {31'd0, wb_err}, 32'd0);
        tick();

        // Full: four loads pushed while the ALU saturates
        for (int i = 0; i < 4; i++) begin
            drive_alu(1'b1, 5'd2, 32'h200 + 32'(i));
            drive_lsu(1'b1, 5'(10 + i), 32'hA0 + 32'(i));
            tick();
        end
        chk("full_ready", {31'd0, lsu_ready}, 32'd0);
        chk("full_stall", {31'd0, alu_stall}, 32'd1);
        chk("full_busy", busy, 32'h0000_3C00);
        // A fifth load is offered while full, and the forced pop happens in the same cycle
        drive_alu(1'b0, 5'd0, 32'd0);
        drive_lsu(1'b1, 5'd20, 32'hEE);
        tick();
        drive_lsu(1'b0, 5'd0, 32'd0);
        chk("full_ready_after_pop", {31'd0, lsu_ready}, 32'd1);
        chk("full_pop_rd", {27'd0, rd}, 32'd10);
        chk("full_pop_wd", write_d, 32'hA0);
        chk("full_busy2", busy, 32'h0000_3C00);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk("full_drain_we", {31'd0, write_e}, 32'd1);
            chk("full_drain_rd", {27'd0, rd}, 32'(10 + i));
            chk("full_drain_wd", write_d, 32'hA0 + 32'(i));
        end
        tick();
        chk("full_no_fifth", {31'd0, write_e}, 32'd0);
        chk("full_busy_end", busy, 32'd0);

        // x0 handling
        drive_alu(1'b1, 5'd0, 32'h55);
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        chk("x0_alu_we", {31'd0, write_e}, 32'd0);
        chk("x0_ld_ready", {31'd0, lsu_ready}, 32'd1);
        drive_lsu(1'b1, 5'd0, 32'h66);
        tick();
        drive_lsu(1'b0, 5'd0, 32'd0);
        chk("x0_ld_busy", busy, 32'd0);
        chk("x0_ld_we1", {31'd0, write_e}, 32'd0);
        tick();
        chk("x0_ld_we2", {31'd0, write_e}, 32'd0);

        // Contract violation: ALU kept valid through the stall cycle
        drive_alu(1'b1, 5'd1, 32'h11);
        drive_lsu(1'b1, 5'd15, 32'hF5);
        tick();
        drive_lsu(1'b0, 5'd0, 32'd0);
        for (int i = 2; i <= 4; i++) begin
            drive_alu(1'b1, 5'(i), 32'h10 + 32'(i));
            tick();
        end
        chk("vio_stall", {31'd0, alu_stall}, 32'd1);
        drive_alu(1'b1, 5'd6, 32'h66);
        tick();
        drive_alu(1'b0, 5'd0, 32'd0);
        chk("vio_err", {31'd0, wb_err}, 32'd1);
        chk("vio_ld_rd", {27'd0, rd}, 32'd15);
        chk("vio_ld_wd", write_d, 32'hF5);
        tick();
        chk("vio_err_sticky", {31'd0, wb_err}, 32'd1);
        chk("vio_dropped", {31'd0, write_e}, 32'd0);

        // Reset with three loads queued behind ALU traffic
        for (int i = 0; i < 3; i++) begin
            drive_alu(1'b1, 5'd3, 32'h300 + 32'(i));
            drive_lsu(1'b1, 5'(21 + i), 32'hB0 + 32'(i));
            tick();
        end
        drive_lsu(1'b0, 5'd0, 32'd0);
        chk("mr_we_before", {31'd0, write_e}, 32'd1);
        chk("mr_busy_before", busy, 32'h00E0_0000);
        #2 rst = 1'b1;
        drive_alu(1'b0, 5'd0, 32'd0);
        #1;
        chk("mr_we", {31'd0, write_e}, 32'd0);
        chk("mr_ready", {31'd0, lsu_ready}, 32'd1);
        chk("mr_busy", busy, 32'd0);
        chk("mr_err_clr", {31'd0, wb_err}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("mr_no_stale_write", {31'd0, write_e}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
